// File: rtl/traffic_light_ctrl_n.sv
// rtl/traffic_light_ctrl_n.sv - N-way round-robin traffic-light controller with parade hold
module traffic_light_ctrl_n #(
    parameter int N_WAY      = 4,
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_MAX  = 32,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1,
    parameter int PARADE_WAY = N_WAY - 1,
    parameter int CNT_W      = $clog2(GREEN_MAX + 1)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [N_WAY-1:0]           i_traff,
    input  logic                       i_mode_p,
    input  logic                       i_mode_r,
    output logic [2*N_WAY-1:0]         o_light,
    output logic [$clog2(N_WAY)-1:0]   o_active_way,
    output logic                       o_parade
);

    localparam int WAY_W = $clog2(N_WAY);

    localparam logic [1:0] LC_GREEN  = 2'd0;
    localparam logic [1:0] LC_YELLOW = 2'd1;
    localparam logic [1:0] LC_RED    = 2'd2;

    // Last cycle index of each timed phase, in timer width
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);

    localparam logic [WAY_W-1:0] PARADE_IDX = WAY_W'(PARADE_WAY);

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic [WAY_W-1:0]       cur, cur_n;
    logic [WAY_W-1:0]       nxt, nxt_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   parade, parade_n;
    logic [2*N_WAY-1:0]     light_q;

    logic                   other_req;
    logic [WAY_W-1:0]       search_way;
    logic                   green_exit;
    logic [WAY_W-1:0]       green_target;

    // Light pattern for a given phase and owning way; every other way stays red
    function automatic logic [2*N_WAY-1:0] light_of(input state_t st, input logic [WAY_W-1:0] w);
        logic [2*N_WAY-1:0] l;
        l = {N_WAY{LC_RED}};
        for (int k = 0; k < N_WAY; k++) begin
            if (w == WAY_W'(k)) begin
                case (st)
                    ST_GREEN:  l[2*k +: 2] = LC_GREEN;
                    ST_YELLOW: l[2*k +: 2] = LC_YELLOW;
                    default:   l[2*k +: 2] = LC_RED;
                endcase
            end
        end
        return l;
    endfunction

    // Cyclic search from cur+1; scanning offsets high-to-low lets the nearest requester win
    always_comb begin
        other_req  = 1'b0;
        search_way = cur;
        for (int k = N_WAY - 1; k >= 1; k--) begin
            if (i_traff[(int'(cur) + k) % N_WAY]) begin
                other_req  = 1'b1;
                search_way = WAY_W'((int'(cur) + k) % N_WAY);
            end
        end
    end

    // Green exit decision, only meaningful once the minimum green has elapsed
    always_comb begin
        green_exit   = 1'b0;
        green_target = search_way;
        if (cnt >= GMIN_LAST) begin
            if (parade) begin
                green_exit   = (cur != PARADE_IDX);
                green_target = PARADE_IDX;
            end else begin
                green_exit   = other_req && (!i_traff[cur] || (cnt >= GMAX_LAST));
                green_target = search_way;
            end
        end
    end

    // Next-state logic: phase sequencing, saturating timer, parade flag
    always_comb begin
        state_n  = state;
        cur_n    = cur;
        nxt_n    = nxt;
        cnt_n    = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;
        parade_n = i_mode_r ? 1'b0 : (i_mode_p ? 1'b1 : parade);
        case (state)
            ST_GREEN: begin
                if (green_exit) begin
                    state_n = ST_YELLOW;
                    nxt_n   = green_target;
                    cnt_n   = '0;
                end
            end
            ST_YELLOW: begin
                if (cnt == YEL_LAST) begin
                    state_n = ST_ALLRED;
                    cnt_n   = '0;
                end
            end
            ST_ALLRED: begin
                if (cnt == AR_LAST) begin
                    state_n = ST_GREEN;
                    cur_n   = nxt;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_GREEN;
                cnt_n   = '0;
            end
        endcase
    end

    // State registers; light code registered from next state so it always matches state/cur
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_GREEN;
            cur     <= '0;
            nxt     <= '0;
            cnt     <= '0;
            parade  <= 1'b0;
            light_q <= light_of(ST_GREEN, '0);
        end else begin
            state   <= state_n;
            cur     <= cur_n;
            nxt     <= nxt_n;
            cnt     <= cnt_n;
            parade  <= parade_n;
            light_q <= light_of(state_n, cur_n);
        end
    end

    assign o_light      = light_q;
    assign o_active_way = cur;
    assign o_parade     = parade;

endmodule
